axi_read_slave: RTL and testbench

AXI3 read-channel responder: accepts read address requests on the AR channel, fetches each beat through a simple synchronous memory read port, and returns data on the R channel with RID, RRESP and RLAST. It sits opposite the read master on the AXI fabric, in the same slave-side position as the write slave, and shares its ACLK/ARESETn domain and its 32-bit data bus.

---
 rtl/axi_read_slave.sv | 139 +++++++++++++
 tb/tb_axi_read_slave.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/axi_read_slave.sv
// AXI3 read-channel slave: accepts one AR burst at a time, fetches each beat from a
// synchronous memory read port and returns it on the R channel with RID/RRESP/RLAST.
module axi_read_slave #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32
) (
  input  logic                  ACLK,
  input  logic                  ARESETn,
  input  logic [3:0]            ARID,
  input  logic [ADDR_WIDTH-1:0] ARADDR,
  input  logic [3:0]            ARLEN,
  input  logic [2:0]            ARSIZE,
  input  logic [1:0]            ARBURST,
  input  logic [1:0]            ARLOCK,
  input  logic [3:0]            ARCACHE,
  input  logic [2:0]            ARPROT,
  input  logic                  ARVALID,
  output logic                  ARREADY,
  output logic [3:0]            RID,
  output logic [DATA_WIDTH-1:0] RDATA,
  output logic [1:0]            RRESP,
  output logic                  RLAST,
  output logic                  RVALID,
  input  logic                  RREADY,
  output logic [ADDR_WIDTH-1:0] memAddr,
  output logic                  memRead,
  input  logic [DATA_WIDTH-1:0] memData
);

  localparam int unsigned MAX_SIZE = $clog2(DATA_WIDTH / 8);

  typedef enum logic [1:0] {IDLE, FETCH, SEND} state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [ADDR_WIDTH-1:0] next_addr;
  logic [ADDR_WIDTH-1:0] bytes;
  logic [ADDR_WIDTH-1:0] bound;
  logic [ADDR_WIDTH-1:0] ar_mask;
  logic [3:0]            len_q;
  logic [3:0]            cnt;
  logic [2:0]            size_q;
  logic [1:0]            burst_q;
  logic                  err_q;
  logic                  ar_err;
  logic                  unused_sideband;

  assign unused_sideband = ^{ARLOCK, ARCACHE, ARPROT};

  always_comb begin
    ar_err  = 1'b0;
    ar_mask = (ADDR_WIDTH'(1) << ARSIZE) - ADDR_WIDTH'(1);
    if (ARBURST == 2'b11) ar_err = 1'b1;
    if (ARSIZE > 3'(MAX_SIZE)) ar_err = 1'b1;
    if (ARBURST == 2'b10) begin
      if (!(ARLEN == 4'd1 || ARLEN == 4'd3 || ARLEN == 4'd7 || ARLEN == 4'd15))
        ar_err = 1'b1;
      if ((ARADDR & ar_mask) != '0) ar_err = 1'b1;
    end
  end

  // WRAP keeps the bits above the wrap boundary and lets only the low part roll over.
  always_comb begin
    bytes     = ADDR_WIDTH'(1) << size_q;
    bound     = (ADDR_WIDTH'(len_q) + ADDR_WIDTH'(1)) * bytes;
    next_addr = addr_q;
    case (burst_q)
      2'b01:   next_addr = addr_q + bytes;
      2'b10:   next_addr = (addr_q & ~(bound - ADDR_WIDTH'(1))) |
                           ((addr_q + bytes) & (bound - ADDR_WIDTH'(1)));
      default: next_addr = addr_q;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      state   <= IDLE;
      ARREADY <= 1'b1;
      RVALID  <= 1'b0;
      RLAST   <= 1'b0;
      RRESP   <= 2'b00;
      RID     <= '0;
      RDATA   <= '0;
      memRead <= 1'b0;
      memAddr <= '0;
      addr_q  <= '0;
      len_q   <= '0;
      cnt     <= '0;
      size_q  <= '0;
      burst_q <= '0;
      err_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          RVALID  <= 1'b0;
          memRead <= 1'b0;
          if (ARVALID && ARREADY) begin
            RID     <= ARID;
            addr_q  <= ARADDR;
            len_q   <= ARLEN;
            size_q  <= ARSIZE;
            burst_q <= ARBURST;
            cnt     <= '0;
            err_q   <= ar_err;
            memAddr <= ARADDR;
            memRead <= !ar_err;
            ARREADY <= 1'b0;
            state   <= FETCH;
          end
        end
        FETCH: begin
          memRead <= 1'b0;
          RDATA   <= err_q ? '0 : memData;
          RRESP   <= err_q ? 2'b10 : 2'b00;
          RLAST   <= (cnt == len_q);
          RVALID  <= 1'b1;
          state   <= SEND;
        end
        SEND: begin
          if (RREADY) begin
            RVALID <= 1'b0;
            if (RLAST) begin
              ARREADY <= 1'b1;
              state   <= IDLE;
            end else begin
              cnt     <= cnt + 4'd1;
              addr_q  <= next_addr;
              memAddr <= next_addr;
              memRead <= !err_q;
              state   <= FETCH;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_read_slave.sv
// Scoreboard bench for axi_read_slave: bursts push expected beats and fetch addresses,
// negedge monitors pop and compare R-channel beats and memory read strobes.
module tb_axi_read_slave;

  logic        clk = 1'b0;
  logic        rstn;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [3:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        arvalid;
  logic        arready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;
  logic [31:0] mem_addr;
  logic        mem_read;
  logic [31:0] mem_data;

  typedef struct {
    logic [31:0] data;
    logic [1:0]  resp;
    logic        last;
    logic [3:0]  id;
  } beat_t;

  beat_t       exp_q[$];
  logic [31:0] addr_exp_q[$];
  int unsigned checks = 0;
  int unsigned errors = 0;
  logic        mon_en = 1'b1;

  always #5 clk = ~clk;

  // Memory model: each word reads back its own address.
  assign mem_data = mem_addr;

  axi_read_slave #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) dut (
    .ACLK(clk), .ARESETn(rstn), .ARID(arid), .ARADDR(araddr), .ARLEN(arlen),
    .ARSIZE(arsize), .ARBURST(arburst), .ARLOCK(2'b00), .ARCACHE(4'h0), .ARPROT(3'b000),
    .ARVALID(arvalid), .ARREADY(arready), .RID(rid), .RDATA(rdata), .RRESP(rresp),
    .RLAST(rlast), .RVALID(rvalid), .RREADY(rready), .memAddr(mem_addr),
    .memRead(mem_read), .memData(mem_data)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en && rvalid && rready) begin
      if (exp_q.size() == 0) check("beat_unexpected", 1, 0);
      else begin
        beat_t b;
        b = exp_q.pop_front();
        check("rdata", rdata, b.data);
        check("rresp", rresp, b.resp);
        check("rlast", rlast, b.last);
        check("rid", rid, b.id);
      end
    end
  end

  always @(negedge clk) begin
    if (mon_en && mem_read) begin
      if (addr_exp_q.size() == 0) check("memread_unexpected", 1, 0);
      else check("memaddr", mem_addr, addr_exp_q.pop_front());
    end
  end

  function automatic logic burst_err(input logic [31:0] a, input logic [3:0] len,
                                     input logic [2:0] size, input logic [1:0] burst);
    logic e;
    e = (burst == 2'b11) || (size > 3'd2);
    if (burst == 2'b10) begin
      if (!(len == 1 || len == 3 || len == 7 || len == 15)) e = 1'b1;
      if ((a % (32'd1 << size)) != 0) e = 1'b1;
    end
    return e;
  endfunction

  task automatic push_burst(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                            input logic [2:0] size, input logic [1:0] burst);
    logic [31:0] a, bytes, bnd, base;
    logic        e;
    beat_t       b;
    e     = burst_err(addr, len, size, burst);
    a     = addr;
    bytes = 32'd1 << size;
    for (int i = 0; i <= int'(len); i++) begin
      b.data = e ? 32'd0 : a;
      b.resp = e ? 2'b10 : 2'b00;
      b.last = (i == int'(len));
      b.id   = id;
      exp_q.push_back(b);
      if (!e) addr_exp_q.push_back(a);
      if (burst == 2'b01) a = a + bytes;
      else if (burst == 2'b10) begin
        bnd  = (32'(len) + 1) * bytes;
        base = a - (a % bnd);
        a    = base + ((a - base + bytes) % bnd);
      end
    end
  endtask

  task automatic send_ar(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                         input logic [2:0] size, input logic [1:0] burst);
    int unsigned n;
    @(posedge clk); #1;
    push_burst(id, addr, len, size, burst);
    arid = id; araddr = addr; arlen = len; arsize = size; arburst = burst; arvalid = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!arready && n < 50);
    if (!arready) check("ar_timeout", 1, 0);
    @(posedge clk); #1;
    arvalid = 1'b0;
    @(negedge clk);
    check("fetch_arready", arready, 0);
    check("fetch_rvalid", rvalid, 0);
    check("fetch_memread", mem_read, !burst_err(addr, len, size, burst));
    @(negedge clk);
    check("first_rvalid", rvalid, 1);
  endtask

  task automatic wait_done();
    int unsigned n;
    n = 0;
    while (!(exp_q.size() == 0 && arready) && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("burst_done", (exp_q.size() == 0 && arready), 1);
    check("fetches_left", addr_exp_q.size(), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    rstn = 1'b0; arvalid = 1'b0; rready = 1'b1;
    arid = '0; araddr = '0; arlen = '0; arsize = '0; arburst = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_arready", arready, 1);
    check("rst_rvalid", rvalid, 0);
    check("rst_rlast", rlast, 0);
    check("rst_rresp", rresp, 0);
    check("rst_rid", rid, 0);
    check("rst_rdata", rdata, 0);
    check("rst_memread", mem_read, 0);
    check("rst_memaddr", mem_addr, 0);
    @(posedge clk); #1 rstn = 1'b1;

    send_ar(4'd5, 32'h100, 4'd3, 3'd2, 2'b01); wait_done();
    send_ar(4'd2, 32'h208, 4'd3, 3'd2, 2'b10); wait_done();
    send_ar(4'd3, 32'h40,  4'd2, 3'd2, 2'b00); wait_done();
    send_ar(4'd1, 32'h80,  4'd7, 3'd0, 2'b01); wait_done();
    send_ar(4'd6, 32'h3F0, 4'd1, 3'd1, 2'b10); wait_done();

    // Backpressure on the second beat
    send_ar(4'd4, 32'h300, 4'd1, 3'd2, 2'b01);
    @(posedge clk); #1 rready = 1'b0;
    for (int i = 0; i < 10 && !rvalid; i++) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      check("stall_rvalid", rvalid, 1);
      check("stall_rdata", rdata, 32'h304);
      check("stall_rlast", rlast, 1);
      @(negedge clk);
    end
    @(posedge clk); #1 rready = 1'b1;
    wait_done();

    send_ar(4'd7, 32'h500, 4'd3, 3'b101, 2'b01); wait_done();
    send_ar(4'd8, 32'h600, 4'd3, 3'd2, 2'b11);   wait_done();
    send_ar(4'd10, 32'h700, 4'd2, 3'd2, 2'b10);  wait_done();
    send_ar(4'd11, 32'h702, 4'd3, 3'd2, 2'b10);  wait_done();

    // Reset in the middle of beat 2 of an 8-beat burst
    mon_en = 1'b0;
    send_ar(4'd12, 32'h800, 4'd7, 3'd2, 2'b01);
    @(posedge clk); #1;
    @(posedge clk); #1 rstn = 1'b0;
    @(posedge clk); #1 rstn = 1'b1;
    @(negedge clk);
    check("midrst_rvalid", rvalid, 0);
    check("midrst_arready", arready, 1);
    check("midrst_memread", mem_read, 0);
    exp_q.delete();
    addr_exp_q.delete();
    mon_en = 1'b1;
    repeat (3) @(negedge clk);
    check("midrst_quiet", rvalid, 0);
    send_ar(4'd9, 32'h900, 4'd3, 3'd2, 2'b01); wait_done();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
